// File: rtl/gt_init_pkg.sv
// Shared types and defaults for the GT lane initialisation sequencer.
package gt_init_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_GT_RST    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_LINK = 3'd4,
    S_READY     = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  localparam int unsigned DEF_RST_HOLD     = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT = 4096;
  localparam int unsigned DEF_DONE_TIMEOUT = 8192;
  localparam int unsigned DEF_LINK_STABLE  = 1024;
  localparam int unsigned DEF_RETRY_MAX    = 7;
  localparam int unsigned DEF_CNT_W        = 16;

  typedef struct packed {
    logic pll_reset;
    logic gt_reset;
    logic ready;
    logic fail;
  } ctrl_t;

  // Output levels that hold for the whole time the FSM sits in state s.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '{pll_reset: 1'b0, gt_reset: 1'b0, ready: 1'b0, fail: 1'b0};
    case (s)
      S_PLL_RST: begin
        c.pll_reset = 1'b1;
        c.gt_reset  = 1'b1;
      end
      S_WAIT_LOCK, S_GT_RST: c.gt_reset = 1'b1;
      S_WAIT_DONE, S_WAIT_LINK: ;
      S_READY: c.ready = 1'b1;
      S_FAIL: begin
        c.pll_reset = 1'b1;
        c.gt_reset  = 1'b1;
        c.fail      = 1'b1;
      end
      default: begin
        c.pll_reset = 1'b1;
        c.gt_reset  = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gt_init_timer.sv
// Clearable saturating cycle counter with a terminal-count compare, shared by all states.
module gt_init_timer #(
  parameter int unsigned C_CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clr,
  input  logic               inc,
  input  logic [C_CNT_W-1:0] tc_val,
  output logic               tc_hit
);

  logic [C_CNT_W-1:0] cnt;
  logic               sat;

  assign sat = &cnt;

  // Clear wins over increment; holding at all-ones keeps a stuck state from wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc_hit = (cnt == tc_val);

endmodule

// File: rtl/gt_init_seq.sv
// Reset/initialisation sequencer for one 10G GT lane: PLL reset, GT reset, link qualification,
// with timeout retries, restart and link/lock loss recovery.
module gt_init_seq
  import gt_init_pkg::*;
#(
  parameter int unsigned C_RST_HOLD     = DEF_RST_HOLD,
  parameter int unsigned C_LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned C_DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter int unsigned C_LINK_STABLE  = DEF_LINK_STABLE,
  parameter int unsigned C_RETRY_MAX    = DEF_RETRY_MAX,
  parameter int unsigned C_CNT_W        = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       restart_i,
  input  logic       pll_lock_i,
  input  logic       tx_resetdone_i,
  input  logic       rx_resetdone_i,
  input  logic       link_up_i,
  output logic       pll_reset_o,
  output logic       gt_txreset_o,
  output logic       gt_rxreset_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam logic [C_CNT_W-1:0] TC_RST_HOLD = C_CNT_W'(C_RST_HOLD - 1);
  localparam logic [C_CNT_W-1:0] TC_LOCK     = C_CNT_W'(C_LOCK_TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0] TC_DONE     = C_CNT_W'(C_DONE_TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0] TC_LINK     = C_CNT_W'(C_LINK_STABLE - 1);
  localparam logic [2:0]         RETRY_MAX   = 3'(C_RETRY_MAX);

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         retry_q;
  logic [2:0]         retry_d;
  logic [C_CNT_W-1:0] tc_val;
  logic               tc_hit;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               link_clr;
  logic               retry_req;
  ctrl_t              ctrl_d;

  // Terminal count depends only on the current state, so one counter serves all phases.
  always_comb begin
    tc_val = '1;
    case (state_q)
      S_PLL_RST, S_GT_RST: tc_val = TC_RST_HOLD;
      S_WAIT_LOCK:         tc_val = TC_LOCK;
      S_WAIT_DONE:         tc_val = TC_DONE;
      S_WAIT_LINK:         tc_val = TC_LINK;
      default:             tc_val = '1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    link_clr  = 1'b0;
    retry_req = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (tc_hit) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (pll_lock_i)  state_d   = S_GT_RST;
        else if (tc_hit) retry_req = 1'b1;
      end
      S_GT_RST: begin
        if (!pll_lock_i) state_d = S_PLL_RST;
        else if (tc_hit) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!pll_lock_i)                          state_d   = S_PLL_RST;
        else if (tx_resetdone_i && rx_resetdone_i) state_d   = S_WAIT_LINK;
        else if (tc_hit)                          retry_req = 1'b1;
      end
      S_WAIT_LINK: begin
        // The counter here measures consecutive link-up cycles, so any drop restarts it.
        if (!pll_lock_i)     state_d  = S_PLL_RST;
        else if (!link_up_i) link_clr = 1'b1;
        else if (tc_hit)     state_d  = S_READY;
      end
      S_READY: begin
        if (!pll_lock_i)     state_d = S_PLL_RST;
        else if (!link_up_i) state_d = S_WAIT_LINK;
      end
      S_FAIL: ;
      default: state_d = S_PLL_RST;
    endcase

    if (retry_req) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = S_PLL_RST;
      end else begin
        state_d = S_FAIL;
      end
    end

    if (state_d == S_READY && state_q != S_READY) retry_d = '0;

    if (restart_i) begin
      state_d = S_PLL_RST;
      retry_d = '0;
    end
  end

  assign cnt_clr = restart_i || (state_d != state_q) || link_clr;
  assign cnt_inc = (state_q != S_READY) && (state_q != S_FAIL);
  assign ctrl_d  = state_ctrl(state_d);

  gt_init_timer #(
    .C_CNT_W (C_CNT_W)
  ) u_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .tc_val (tc_val),
    .tc_hit (tc_hit)
  );

  // Outputs are registered from the next state so they always agree with state_o.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_PLL_RST;
      retry_q      <= '0;
      pll_reset_o  <= 1'b1;
      gt_txreset_o <= 1'b1;
      gt_rxreset_o <= 1'b1;
      ready_o      <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      pll_reset_o  <= ctrl_d.pll_reset;
      gt_txreset_o <= ctrl_d.gt_reset;
      gt_rxreset_o <= ctrl_d.gt_reset;
      ready_o      <= ctrl_d.ready;
      fail_o       <= ctrl_d.fail;
    end
  end

  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_gt_init_seq.sv
// Scenario bench for gt_init_seq: bring-up, retries to FAIL, link glitches, lock loss, restart, async reset.
module tb_gt_init_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       restart_i = 1'b0;
  logic       pll_lock_i = 1'b0;
  logic       tx_resetdone_i = 1'b0;
  logic       rx_resetdone_i = 1'b0;
  logic       link_up_i = 1'b0;
  logic       pll_reset_o;
  logic       gt_txreset_o;
  logic       gt_rxreset_o;
  logic       ready_o;
  logic       fail_o;
  logic [2:0] retry_cnt_o;
  logic [2:0] state_o;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;
  int         cyc;

  gt_init_seq dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .restart_i      (restart_i),
    .pll_lock_i     (pll_lock_i),
    .tx_resetdone_i (tx_resetdone_i),
    .rx_resetdone_i (rx_resetdone_i),
    .link_up_i      (link_up_i),
    .pll_reset_o    (pll_reset_o),
    .gt_txreset_o   (gt_txreset_o),
    .gt_rxreset_o   (gt_rxreset_o),
    .ready_o        (ready_o),
    .fail_o         (fail_o),
    .retry_cnt_o    (retry_cnt_o),
    .state_o        (state_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int c);
    c = 0;
    while (state_o !== s && c < budget) begin
      tick(1);
      c++;
    end
    if (state_o !== s) c = -1;
  endtask

  task automatic wait_ready(input int budget, output int c);
    c = 0;
    while (ready_o !== 1'b1 && c < budget) begin
      tick(1);
      c++;
    end
    if (ready_o !== 1'b1) c = -1;
  endtask

  task automatic wait_retry(input logic [2:0] v, input int budget, output int c);
    c = 0;
    while (retry_cnt_o !== v && c < budget) begin
      tick(1);
      c++;
    end
    if (retry_cnt_o !== v) c = -1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick(3);
    checks++;
    if ({state_o, retry_cnt_o} !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d retry=%0d, expected 0/0", state_o, retry_cnt_o);
    end
    checks++;
    if ({pll_reset_o, gt_txreset_o, gt_rxreset_o, ready_o, fail_o} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 11100",
               {pll_reset_o, gt_txreset_o, gt_rxreset_o, ready_o, fail_o});
    end
  endtask

  task automatic test_nominal;
    int n;
    link_up_i = 1'b1;
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    RST_N = 1'b1;
    n = 0;
    while (pll_reset_o === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL pll_reset_hold: got %0d cycles expected 16", n);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (state_o !== exp_v) begin
      errors++;
      $display("FAIL enter_wait_lock: got state %0d expected %0d", state_o, exp_v);
    end
    tick(40 - 16);
    pll_lock_i = 1'b1;
    exp_v = exp_q.pop_front();
    wait_state(exp_v, 4, cyc);
    checks++;
    if ({state_o, pll_reset_o, gt_txreset_o, gt_rxreset_o} !== {exp_v, 3'b011}) begin
      errors++;
      $display("FAIL gt_rst_outputs: got state=%0d resets=%b expected %0d/011", state_o,
               {pll_reset_o, gt_txreset_o, gt_rxreset_o}, exp_v);
    end
    tick(100);
    exp_v = exp_q.pop_front();
    checks++;
    if ({state_o, pll_reset_o, gt_txreset_o, gt_rxreset_o} !== {exp_v, 3'b000}) begin
      errors++;
      $display("FAIL wait_done_outputs: got state=%0d resets=%b expected %0d/000", state_o,
               {pll_reset_o, gt_txreset_o, gt_rxreset_o}, exp_v);
    end
    tx_resetdone_i = 1'b1;
    rx_resetdone_i = 1'b1;
    exp_v = exp_q.pop_front();
    wait_state(exp_v, 4, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL wait_link_entry: got %0d cycles expected 1", cyc);
    end
    wait_ready(1100, cyc);
    checks++;
    if (cyc !== 1024) begin
      errors++;
      $display("FAIL link_stable_time: got %0d cycles expected 1024", cyc);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if ({state_o, retry_cnt_o} !== {exp_v, 3'd0}) begin
      errors++;
      $display("FAIL ready_state: got state=%0d retry=%0d expected %0d/0", state_o, retry_cnt_o, exp_v);
    end
  endtask

  task automatic test_link_glitch;
    link_up_i = 1'b0;
    tick(1);
    link_up_i = 1'b1;
    checks++;
    if ({ready_o, state_o, gt_txreset_o, gt_rxreset_o, pll_reset_o} !== {1'b0, 3'd4, 3'b000}) begin
      errors++;
      $display("FAIL glitch_drop: got ready=%0d state=%0d resets=%b expected 0/4/000", ready_o,
               state_o, {gt_txreset_o, gt_rxreset_o, pll_reset_o});
    end
    wait_ready(1100, cyc);
    checks++;
    if (cyc !== 1024) begin
      errors++;
      $display("FAIL glitch_recover: got %0d cycles expected 1024", cyc);
    end
  endtask

  task automatic test_unstable_link;
    logic saw_ready;
    saw_ready = 1'b0;
    link_up_i = 1'b0;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      link_up_i = 1'b1;
      for (int i = 0; i < 499; i++) begin
        tick(1);
        if (ready_o !== 1'b0) saw_ready = 1'b1;
      end
      link_up_i = 1'b0;
      tick(1);
      if (ready_o !== 1'b0) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready !== 1'b0 || state_o !== 3'd4) begin
      errors++;
      $display("FAIL unstable_link: got saw_ready=%0d state=%0d expected 0/4", saw_ready, state_o);
    end
    link_up_i = 1'b1;
    wait_ready(1100, cyc);
    checks++;
    if (cyc !== 1024) begin
      errors++;
      $display("FAIL unstable_recover: got %0d cycles expected 1024", cyc);
    end
  endtask

  task automatic test_lock_loss;
    tx_resetdone_i = 1'b0;
    rx_resetdone_i = 1'b0;
    pll_lock_i = 1'b0;
    tick(1);
    checks++;
    if ({state_o, pll_reset_o, ready_o, retry_cnt_o} !== {3'd0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL ready_lock_loss: got state=%0d pll=%0d ready=%0d retry=%0d expected 0/1/0/0",
               state_o, pll_reset_o, ready_o, retry_cnt_o);
    end
    exp_q.push_back(3'd1);
    exp_v = exp_q.pop_front();
    wait_retry(exp_v, 4200, cyc);
    checks++;
    if (cyc !== 4112) begin
      errors++;
      $display("FAIL first_retry_time: got %0d cycles expected 4112", cyc);
    end
    pll_lock_i = 1'b1;
    wait_state(3'd3, 100, cyc);
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL reach_wait_done: got state %0d expected 3", state_o);
    end
    pll_lock_i = 1'b0;
    tick(1);
    checks++;
    if ({state_o, pll_reset_o, retry_cnt_o} !== {3'd0, 1'b1, exp_v}) begin
      errors++;
      $display("FAIL done_lock_loss: got state=%0d pll=%0d retry=%0d expected 0/1/%0d",
               state_o, pll_reset_o, retry_cnt_o, exp_v);
    end
  endtask

  task automatic test_restart_vs_timeout;
    wait_state(3'd1, 40, cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL relock_entry: got %0d cycles expected 16", cyc);
    end
    tick(4095);
    checks++;
    if ({state_o, retry_cnt_o} !== {3'd1, 3'd1}) begin
      errors++;
      $display("FAIL pre_timeout: got state=%0d retry=%0d expected 1/1", state_o, retry_cnt_o);
    end
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    checks++;
    if ({state_o, retry_cnt_o, fail_o, pll_reset_o} !== {3'd0, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL restart_wins: got state=%0d retry=%0d fail=%0d pll=%0d expected 0/0/0/1",
               state_o, retry_cnt_o, fail_o, pll_reset_o);
    end
  endtask

  task automatic test_lock_timeout_fail;
    for (int r = 1; r <= 7; r++) exp_q.push_back(3'(r));
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      wait_retry(exp_v, 4200, cyc);
      checks++;
      if (cyc !== 4112 || state_o !== 3'd0) begin
        errors++;
        $display("FAIL retry_step_%0d: got %0d cycles state=%0d expected 4112/0", exp_v, cyc, state_o);
      end
    end
    wait_state(3'd6, 4200, cyc);
    checks++;
    if (cyc !== 4112) begin
      errors++;
      $display("FAIL fail_entry: got %0d cycles expected 4112", cyc);
    end
    checks++;
    if ({pll_reset_o, gt_txreset_o, gt_rxreset_o, ready_o, fail_o} !== 5'b11101) begin
      errors++;
      $display("FAIL fail_outputs: got %b expected 11101",
               {pll_reset_o, gt_txreset_o, gt_rxreset_o, ready_o, fail_o});
    end
    pll_lock_i = 1'b1;
    tick(50);
    checks++;
    if ({state_o, fail_o} !== {3'd6, 1'b1}) begin
      errors++;
      $display("FAIL fail_sticky: got state=%0d fail=%0d expected 6/1", state_o, fail_o);
    end
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    checks++;
    if ({fail_o, state_o, retry_cnt_o} !== {1'b0, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL fail_restart: got fail=%0d state=%0d retry=%0d expected 0/0/0",
               fail_o, state_o, retry_cnt_o);
    end
  endtask

  task automatic test_async_reset;
    tx_resetdone_i = 1'b1;
    rx_resetdone_i = 1'b1;
    link_up_i = 1'b0;
    wait_state(3'd4, 200, cyc);
    checks++;
    if ({state_o, pll_reset_o, gt_txreset_o} !== {3'd4, 2'b00}) begin
      errors++;
      $display("FAIL reach_wait_link: got state=%0d expected 4", state_o);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({state_o, retry_cnt_o, pll_reset_o, gt_txreset_o, gt_rxreset_o, ready_o, fail_o}
        !== {3'd0, 3'd0, 5'b11100}) begin
      errors++;
      $display("FAIL async_reset: got state=%0d retry=%0d outs=%b expected 0/0/11100", state_o,
               retry_cnt_o, {pll_reset_o, gt_txreset_o, gt_rxreset_o, ready_o, fail_o});
    end
    tick(2);
    RST_N = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_link_glitch();
    test_unstable_link();
    test_lock_loss();
    test_restart_vs_timeout();
    test_lock_timeout_fail();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
